button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream conditioning stage for the lab board's push buttons.
- Converts a raw, asynchronous, bouncing button into a synchronised, debounced level plus single-cycle press and release strobes.
- Downstream counters run on the system clock and use `press_pulse` as a count enable, instead of clocking directly off a button.
- One instance per button (e.g. count button, clear button).

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles the synchronised input must hold steady before a level change is accepted; minimum 2 (10 ms at 100 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter; derived, not overridden.
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat pulse; used only with BTN_AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses; used only with BTN_AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_in  input  1  raw button pin; asynchronous, may bounce.
- btn_level  output  1  debounced button level, registered.
- press_pulse  output  1  one-cycle strobe on accepted press (and on auto-repeat ticks when enabled).
- release_pulse  output  1  one-cycle strobe on accepted release.

Behaviour:
- Reset (reset=0):
  - Immediately, without a clock edge: all flops clear, FSM enters IDLE, debounce counter clears to 0.
  - btn_level, press_pulse and release_pulse all read 0.
  - A reset mid-debounce discards the partial count; no pulse is emitted.
- Synchroniser:
  - Two flops, both reset to 0; output is `btn_sync`.
  - Only `btn_sync` feeds the FSM; raw `btn_in` never reaches any logic.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: btn_sync=1 → PRESS_WAIT, counter cleared to 0.
  - PRESS_WAIT:
    - btn_sync=0 → back to IDLE, counter cleared; this is a bounce and no output changes.
    - Otherwise the counter increments.
    - When the counter equals DEBOUNCE_CYCLES-1 with btn_sync=1 → HELD. On that same edge: btn_level←1, press_pulse←1 for exactly one cycle, counter cleared.
  - HELD: btn_sync=0 → RELEASE_WAIT, counter cleared to 0.
  - RELEASE_WAIT:
    - btn_sync=1 → back to HELD, counter cleared; no pulse, btn_level stays 1.
    - Otherwise the counter increments.
    - When the counter equals DEBOUNCE_CYCLES-1 → IDLE. On that edge: btn_level←0, release_pulse←1 for one cycle.
- Latency:
  - Clean rising input first sampled at edge 1 → press_pulse is high in the cycle after edge DEBOUNCE_CYCLES+3.
  - Release is symmetric.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
  - Cleared on every state transition.
- Outputs:
  - press_pulse and release_pulse are never high in the same cycle.
  - Two consecutive press pulses are never adjacent.
- Button already held when reset deasserts: treated as a fresh press, so press_pulse fires after the full debounce latency.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter runs only while in HELD; it clears whenever the state is not HELD.
  - First extra press_pulse fires REPEAT_DELAY cycles after entering HELD.
  - Further pulses follow every REPEAT_PERIOD cycles while in HELD.
  - Leaving HELD, even to RELEASE_WAIT on a bounce, restarts the delay.
- Undefined:
  - No repeat logic is present.
  - Exactly one press_pulse per accepted press; REPEAT_* parameters are ignored.

Decomposition:
- Shared package btn_pkg:
  - 2-bit state encoding: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3.
  - Default DEBOUNCE_CYCLES / REPEAT_* constants for the 100 MHz board clock.
- Sub-module sync_2ff: generic two-flop synchroniser with the same clk and reset. It is reused by any other block taking a switch or button input.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Clean press: btn_in 0→1 before edge 1, held → press_pulse=1 only in the cycle after edge 7; btn_level=1 from the same edge; release_pulse stays 0.
- Bounce rejection: btn_in toggles 1,0,1,0 every 2 cycles, then stays 0 → no pulses, btn_level stays 0, FSM ends in IDLE.
- Release with glitch: from HELD, drop btn_in for 2 cycles, restore for 1, then drop for good → btn_level falls, and release_pulse=1 for one cycle, exactly 7 edges after the final drop; the 2-cycle drop produces nothing.
- Reset mid-debounce: assert reset=0 between clk edges while in PRESS_WAIT → all outputs read 0 immediately. Release reset with btn_in=1 → press_pulse arrives 7 edges later.
- Auto-repeat (macro defined): hold for 20 cycles past the press → extra press_pulse at HELD+8, +11, +14, +17, +20; with macro undefined, only the initial pulse.
- Back-to-back presses: press, full release, press again → exactly two press_pulse and one release_pulse between them; pulses are never in the same cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and board defaults for the push-button conditioning blocks.
// Defaults assume the 100 MHz lab board clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 100 ms

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous switch/button inputs.
// Latency 2 clk cycles; no flow control, samples every cycle.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Raw bouncing button -> synchronised debounced level plus one-cycle press/release strobes.
// Press strobe DEBOUNCE_CYCLES+3 edges after a clean edge; no backpressure; BTN_AUTO_REPEAT_EN adds held repeats.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic             btn_sync;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;
  logic             rpt_fire;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // Counter is cleared on every transition, so it never passes CNT_LAST.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = rpt_fire;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_target;
  logic             rpt_armed;

  // Once the first repeat has fired, later repeats use the shorter period.
  assign rpt_target = rpt_armed ? PERIOD_LAST : DELAY_LAST;
  assign rpt_fire   = (state == HELD) && btn_sync && (rpt_cnt == rpt_target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (state != HELD) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule
